// File: rtl/bcd_key_entry_pkg.sv
// Shared types and constants for the push-button BCD entry block.
package bcd_key_entry_pkg;

  typedef enum logic [1:0] {
    EDIT_LO = 2'd0,
    EDIT_HI = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  localparam int unsigned BCD_W = 4;
  localparam int unsigned BIN_W = 7;
  localparam logic [BCD_W-1:0] DIGIT_MAX = 4'd9;

  function automatic logic [BCD_W-1:0] inc_digit(input logic [BCD_W-1:0] d);
    return (d == DIGIT_MAX) ? '0 : d + 4'd1;
  endfunction

  function automatic logic [BIN_W-1:0] bcd_to_bin(input logic [BCD_W-1:0] tens,
                                                  input logic [BCD_W-1:0] units);
    return 7'(tens) * 7'd10 + 7'(units);
  endfunction

endpackage

// File: rtl/bcd_key_entry_if.sv
// Key inputs and display/commit outputs of the BCD entry block as one bundle.
interface bcd_key_entry_if;
  import bcd_key_entry_pkg::*;

  logic [2:0]       KEY;
  logic [BCD_W-1:0] BCD0;
  logic [BCD_W-1:0] BCD1;
  logic             SEL;
  logic [BIN_W-1:0] Bin;
  logic             VALID;
  logic             ERR;

  modport master (output KEY, input BCD0, BCD1, SEL, Bin, VALID, ERR);
  modport slave  (input KEY, output BCD0, BCD1, SEL, Bin, VALID, ERR);
endinterface

// File: rtl/bcd_key_entry_debounce.sv
// Per-key 2-FF synchroniser, hold-time debounce and press-edge pulse.
module key_debounce #(
  parameter int unsigned DB_CNT = 50000
) (
  input  logic CP,
  input  logic CLR_,
  input  logic i_key,
  output logic o_press
);
  localparam logic [15:0] CNT_LAST = 16'(DB_CNT - 1);

  logic        r_sync0, r_sync1, r_stable, r_press, r_armed;
  logic [1:0]  r_warm;
  logic [15:0] r_cnt;

  // Presses are only reported once the key has been seen released after reset,
  // so a key held through reset release stays silent until pressed again.
  always_ff @(posedge CP or negedge CLR_) begin
    if (!CLR_) begin
      r_sync0  <= 1'b1;
      r_sync1  <= 1'b1;
      r_stable <= 1'b1;
      r_press  <= 1'b0;
      r_armed  <= 1'b0;
      r_warm   <= '0;
      r_cnt    <= '0;
    end else begin
      r_sync0 <= i_key;
      r_sync1 <= r_sync0;
      r_warm  <= {r_warm[0], 1'b1};
      r_press <= 1'b0;
      if (r_warm[1] && r_stable && r_sync1) r_armed <= 1'b1;
      if (r_sync1 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt    <= '0;
        r_stable <= r_sync1;
        r_press  <= r_armed & ~r_sync1;
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  assign o_press = r_press;
endmodule

// File: rtl/bcd_key_entry.sv
// Two-digit BCD editor driven by three debounced keys; commits a clamped binary value.
module bcd_key_entry
  import bcd_key_entry_pkg::*;
#(
  parameter int unsigned DB_CNT  = 50000,
  parameter int unsigned MAX_VAL = 99
) (
  input  logic             CP,
  input  logic             CLR_,
  input  logic [2:0]       KEY,
  output logic [BCD_W-1:0] BCD0,
  output logic [BCD_W-1:0] BCD1,
  output logic             SEL,
  output logic [BIN_W-1:0] Bin,
  output logic             VALID,
  output logic             ERR
);
  localparam logic [BIN_W-1:0] MAX_BIN = 7'(MAX_VAL);

  logic [2:0]       w_press;
  logic [BIN_W-1:0] w_val;
  logic             w_over;

  state_t           r_state;
  logic [BCD_W-1:0] r_bcd0, r_bcd1;
  logic [BIN_W-1:0] r_bin;
  logic             r_sel, r_valid, r_err;

  for (genvar g = 0; g < 3; g++) begin : g_key
    key_debounce #(.DB_CNT(DB_CNT)) u_db (
      .CP     (CP),
      .CLR_   (CLR_),
      .i_key  (KEY[g]),
      .o_press(w_press[g])
    );
  end

  assign w_val  = bcd_to_bin(r_bcd1, r_bcd0);
  assign w_over = (w_val > MAX_BIN);

  // Event priority: enter (2) over select (1) over increment (0).
  always_ff @(posedge CP or negedge CLR_) begin
    if (!CLR_) begin
      r_state <= EDIT_LO;
      r_bcd0  <= '0;
      r_bcd1  <= '0;
      r_bin   <= '0;
      r_sel   <= 1'b0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        EDIT_LO, EDIT_HI: begin
          if (w_press[2]) begin
            r_state <= COMMIT;
            r_sel   <= 1'b0;
          end else if (w_press[1]) begin
            r_state <= (r_state == EDIT_LO) ? EDIT_HI : EDIT_LO;
            r_sel   <= (r_state == EDIT_LO);
          end else if (w_press[0]) begin
            if (r_state == EDIT_HI) r_bcd1 <= inc_digit(r_bcd1);
            else                    r_bcd0 <= inc_digit(r_bcd0);
          end
        end
        COMMIT: begin
          r_bin   <= w_over ? MAX_BIN : w_val;
          r_err   <= w_over;
          r_valid <= 1'b1;
          r_sel   <= 1'b0;
          r_state <= EDIT_LO;
        end
        default: begin
          r_state <= EDIT_LO;
          r_sel   <= 1'b0;
        end
      endcase
    end
  end

  assign BCD0  = r_bcd0;
  assign BCD1  = r_bcd1;
  assign SEL   = r_sel;
  assign Bin   = r_bin;
  assign VALID = r_valid;
  assign ERR   = r_err;
endmodule

// File: tb/tb_bcd_key_entry.sv
// Directed bench for bcd_key_entry: DUT a clamps at 99, DUT b clamps at 20, DB_CNT = 4.
module tb_bcd_key_entry;
  localparam int unsigned DB = 4;

  logic CP = 1'b0;
  logic CLR_ = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  bcd_key_entry_if ifa ();
  bcd_key_entry_if ifb ();

  bcd_key_entry #(.DB_CNT(DB), .MAX_VAL(99)) dut_a (
    .CP(CP), .CLR_(CLR_), .KEY(ifa.KEY), .BCD0(ifa.BCD0), .BCD1(ifa.BCD1),
    .SEL(ifa.SEL), .Bin(ifa.Bin), .VALID(ifa.VALID), .ERR(ifa.ERR));

  bcd_key_entry #(.DB_CNT(DB), .MAX_VAL(20)) dut_b (
    .CP(CP), .CLR_(CLR_), .KEY(ifb.KEY), .BCD0(ifb.BCD0), .BCD1(ifb.BCD1),
    .SEL(ifb.SEL), .Bin(ifb.Bin), .VALID(ifb.VALID), .ERR(ifb.ERR));

  always #5 CP = ~CP;

  logic [2:0] key_m [2];
  logic [3:0] bcd0_m [2], bcd1_m [2];
  logic [6:0] bin_m [2];
  logic       sel_m [2], valid_m [2], err_m [2];

  assign ifa.KEY = key_m[0];
  assign ifb.KEY = key_m[1];
  assign bcd0_m[0] = ifa.BCD0;   assign bcd0_m[1] = ifb.BCD0;
  assign bcd1_m[0] = ifa.BCD1;   assign bcd1_m[1] = ifb.BCD1;
  assign bin_m[0]  = ifa.Bin;    assign bin_m[1]  = ifb.Bin;
  assign sel_m[0]  = ifa.SEL;    assign sel_m[1]  = ifb.SEL;
  assign valid_m[0] = ifa.VALID; assign valid_m[1] = ifb.VALID;
  assign err_m[0]  = ifa.ERR;    assign err_m[1]  = ifb.ERR;

  typedef struct {
    int d;       // which DUT
    int k;       // key index pressed
    int e_bcd0;
    int e_bcd1;
    int e_sel;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CP);
    #1;
  endtask

  task automatic do_reset();
    #2 CLR_ = 1'b0;
    tick(2);
    CLR_ = 1'b1;
    tick(4);
  endtask

  task automatic press(input int d, input int k);
    key_m[d][k] = 1'b0;
    tick(DB + 3);
    key_m[d][k] = 1'b1;
    tick(DB + 4);
  endtask

  // Raw fall lands just after an edge; the event is acted on 7 edges later,
  // so COMMIT occupies the cycle after edge 7 and VALID follows edge 8.
  task automatic commit_check(input int d, input logic [2:0] mask, input int e_bin,
                              input int e_err, input int e_b0, input int e_b1);
    key_m[d] = key_m[d] & ~mask;
    tick(DB + 3);
    chk("valid_pre", valid_m[d], 0);
    chk("sel_commit", sel_m[d], 0);
    tick(1);
    chk("valid_pulse", valid_m[d], 1);
    chk("bin", bin_m[d], e_bin);
    chk("err", err_m[d], e_err);
    tick(1);
    chk("valid_post", valid_m[d], 0);
    key_m[d] = 3'b111;
    tick(DB + 4);
    chk("bin_hold", bin_m[d], e_bin);
    chk("bcd0_keep", bcd0_m[d], e_b0);
    chk("bcd1_keep", bcd1_m[d], e_b1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    key_m[0] = 3'b111;
    key_m[1] = 3'b111;

    for (int v = 4; v <= 9; v++) vecs.push_back('{0, 0, v, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0});
    vecs.push_back('{0, 1, 0, 0, 1});
    for (int v = 1; v <= 4; v++) vecs.push_back('{0, 0, 0, v, 1});
    vecs.push_back('{0, 1, 0, 4, 0});
    for (int v = 1; v <= 7; v++) vecs.push_back('{0, 0, v, 4, 0});

    // Reset state with all keys released.
    do_reset();
    for (int d = 0; d < 2; d++) begin
      chk("rst_bcd0", bcd0_m[d], 0);
      chk("rst_bcd1", bcd1_m[d], 0);
      chk("rst_sel", sel_m[d], 0);
      chk("rst_bin", bin_m[d], 0);
      chk("rst_valid", valid_m[d], 0);
      chk("rst_err", err_m[d], 0);
    end

    // Key held through reset release: silent until released and pressed again.
    CLR_ = 1'b0;
    key_m[0][0] = 1'b0;
    tick(2);
    CLR_ = 1'b1;
    tick(20);
    chk("held_no_event", bcd0_m[0], 0);
    key_m[0][0] = 1'b1;
    tick(10);
    chk("held_release", bcd0_m[0], 0);
    press(0, 0);
    chk("held_repress", bcd0_m[0], 1);
    do_reset();
    chk("rst2_bcd0", bcd0_m[0], 0);

    // Update lands on edge t+2+DB where t is the first edge after the fall.
    for (int i = 1; i <= 3; i++) begin
      key_m[0][0] = 1'b0;
      tick(DB + 2);
      chk("inc_early", bcd0_m[0], i - 1);
      tick(1);
      chk("inc_edge", bcd0_m[0], i);
      key_m[0][0] = 1'b1;
      tick(DB + 4);
    end

    foreach (vecs[i]) begin
      press(vecs[i].d, vecs[i].k);
      chk($sformatf("vec%0d_bcd0", i), bcd0_m[vecs[i].d], vecs[i].e_bcd0);
      chk($sformatf("vec%0d_bcd1", i), bcd1_m[vecs[i].d], vecs[i].e_bcd1);
      chk($sformatf("vec%0d_sel", i), sel_m[vecs[i].d], vecs[i].e_sel);
    end

    commit_check(0, 3'b100, 47, 0, 7, 4);

    // Bounce: low 3, high 1, low 3, then released; never DB consecutive cycles.
    key_m[0][0] = 1'b0; tick(3);
    key_m[0][0] = 1'b1; tick(1);
    key_m[0][0] = 1'b0; tick(3);
    key_m[0][0] = 1'b1; tick(12);
    chk("bounce_bcd0", bcd0_m[0], 7);

    // Clamp on DUT b: enter 35 against MAX_VAL = 20.
    press(1, 1);
    chk("b_sel_hi", sel_m[1], 1);
    for (int v = 1; v <= 3; v++) begin
      press(1, 0);
      chk("b_bcd1", bcd1_m[1], v);
    end
    press(1, 1);
    chk("b_sel_lo", sel_m[1], 0);
    for (int v = 1; v <= 5; v++) begin
      press(1, 0);
      chk("b_bcd0", bcd0_m[1], v);
    end
    commit_check(1, 3'b100, 20, 1, 5, 3);

    // Enter and increment in the same cycle: enter wins, increment dropped.
    commit_check(0, 3'b101, 47, 0, 7, 4);

    // Asynchronous reset during the COMMIT cycle.
    key_m[0][2] = 1'b0;
    tick(DB + 3);
    chk("clr_pre_valid", valid_m[0], 0);
    CLR_ = 1'b0;
    #2;
    chk("clr_bin", bin_m[0], 0);
    chk("clr_valid", valid_m[0], 0);
    tick(2);
    chk("clr_hold_valid", valid_m[0], 0);
    chk("clr_hold_bin", bin_m[0], 0);
    chk("clr_bcd1", bcd1_m[0], 0);
    key_m[0][2] = 1'b1;
    CLR_ = 1'b1;
    tick(12);
    chk("clr_after_valid", valid_m[0], 0);
    chk("clr_after_bin", bin_m[0], 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
